// File: rtl/addsub_pkg.sv
// Shared types and constant helpers for the pipelined adder/subtractor.
// stage_t holds the per-stage control bits; data vectors live beside it.
package addsub_pkg;

  localparam int MAX_W = 1024;

  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic bb_msb;
  } stage_t;

  function automatic int stages(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic logic [MAX_W-1:0] sat_max(input int width);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < width - 1; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] sat_min(input int width);
    logic [MAX_W-1:0] m;
    m = '0;
    m[width-1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG-bit ripple-carry full-adder chain.
// One instance resolves one pipeline stage worth of result bits.
module addsub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic cy;

  always_comb begin
    s  = '0;
    cy = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    co = cy;
  end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/sub, one SEG-bit segment per stage, global-stall handshake.
// Define PIPE_ADDSUB_SATURATE_EN to clamp overflowing results in the last stage.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int ST = stages(WIDTH, SEG);

  if (WIDTH % SEG != 0 || ST < 1 || ST > 16) begin : g_bad_cfg
    $error("pipe_addsub: WIDTH must be SEG*(1..16)");
  end

`ifdef PIPE_ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  stage_t           ctl_q [ST];
  stage_t           ctl_d [ST];
  logic [WIDTH-1:0] sum_q [ST];
  logic [WIDTH-1:0] sum_d [ST];
  logic [WIDTH-1:0] a_q   [ST];
  logic [WIDTH-1:0] a_d   [ST];
  logic [WIDTH-1:0] bb_q  [ST];
  logic [WIDTH-1:0] bb_d  [ST];
  logic             ovf_q;
  logic             ovf_d;
  logic             advance;

  assign advance   = !ctl_q[ST-1].valid || out_ready;
  assign in_ready  = advance && !rst;
  assign out_valid = ctl_q[ST-1].valid;
  assign sum       = sum_q[ST-1];
  assign cout      = ctl_q[ST-1].carry;
  assign ovf       = ovf_q;

  for (genvar k = 0; k < ST; k++) begin : g_st
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_bb;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] raw;
    logic [SEG-1:0]   ss;
    logic             src_c;
    logic             src_v;
    logic             src_am;
    logic             src_bm;
    logic             co;

    if (k == 0) begin : g_first
      assign src_a   = a;
      assign src_bb  = sub ? ~b : b;
      assign src_sum = '0;
      assign src_c   = cin ^ sub;
      assign src_v   = in_valid;
      assign src_am  = a[WIDTH-1];
      assign src_bm  = src_bb[WIDTH-1];
    end else begin : g_next
      assign src_a   = a_q[k-1];
      assign src_bb  = bb_q[k-1];
      assign src_sum = sum_q[k-1];
      assign src_c   = ctl_q[k-1].carry;
      assign src_v   = ctl_q[k-1].valid;
      assign src_am  = ctl_q[k-1].a_msb;
      assign src_bm  = ctl_q[k-1].bb_msb;
    end

    addsub_seg #(.SEG(SEG)) u_seg (
      .a  (src_a[SEG-1:0]),
      .b  (src_bb[SEG-1:0]),
      .ci (src_c),
      .s  (ss),
      .co (co)
    );

    // Resolved bits enter at the top; after ST shifts they sit in place.
    assign raw = (src_sum >> SEG) | (WIDTH'(ss) << (WIDTH - SEG));

    assign ctl_d[k] = '{valid: src_v, carry: co,
                        a_msb: src_am, bb_msb: src_bm};
    assign a_d[k]   = src_a >> SEG;
    assign bb_d[k]  = src_bb >> SEG;

    if (k == ST - 1) begin : g_last
      assign ovf_d = (src_am == src_bm) && (ss[SEG-1] != src_am);
`ifdef PIPE_ADDSUB_SATURATE_EN
      assign sum_d[k] = ovf_d ? (src_am ? SAT_MIN : SAT_MAX) : raw;
`else
      assign sum_d[k] = raw;
`endif
    end else begin : g_mid
      assign sum_d[k] = raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ST; k++) begin
        ctl_q[k] <= '0;
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        bb_q[k]  <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < ST; k++) begin
        ctl_q[k] <= ctl_d[k];
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        bb_q[k]  <= bb_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and random bench for pipe_addsub (WIDTH=16, SEG=4).
// Expectations follow PIPE_ADDSUB_SATURATE_EN when it is defined.
module tb_pipe_addsub;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int errors;
  int checks;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

`ifdef PIPE_ADDSUB_SATURATE_EN
  localparam logic [15:0] EXP_MIN_SUB = 16'h8000;
  localparam logic [15:0] EXP_MAX_ADD = 16'h7FFF;
`else
  localparam logic [15:0] EXP_MIN_SUB = 16'h7FFF;
  localparam logic [15:0] EXP_MAX_ADD = 16'h8000;
`endif

  pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] x,
                                 input logic [15:0] y,
                                 input logic ci,
                                 input logic sb);
    logic [15:0] yy;
    logic [16:0] t;
    res_t r;
    yy  = sb ? ~y : y;
    t   = {1'b0, x} + {1'b0, yy} + 17'(ci ^ sb);
    r.s = t[15:0];
    r.c = t[16];
    r.o = (x[15] == yy[15]) && (t[15] != x[15]);
`ifdef PIPE_ADDSUB_SATURATE_EN
    if (r.o) r.s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts,
                          output logic [15:0] rs, output logic rc,
                          output logic ro, output int lat);
    a = ta; b = tb; cin = tc; sub = ts;
    in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; rs = '0; rc = 1'b0; ro = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_valid) begin
        lat = i; rs = sum; rc = cout; ro = ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    end
    if (sum !== 16'h0) begin
      errors++; $display("FAIL rst_sum got=%h exp=0000", sum);
    end
    if (cout !== 1'b0) begin
      errors++; $display("FAIL rst_cout got=%b exp=0", cout);
    end
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL rst_ovf got=%b exp=0", ovf);
    end
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic check_beat(input string nm,
                            input logic [15:0] ta, input logic [15:0] tb,
                            input logic tc, input logic ts,
                            input logic [15:0] es, input logic ec,
                            input logic eo);
    logic [15:0] rs;
    logic rc, ro;
    int lat;
    run_beat(ta, tb, tc, ts, rs, rc, ro, lat);
    checks += 4;
    if (lat != 4) begin
      errors++; $display("FAIL %s latency got=%0d exp=4", nm, lat);
    end
    if (rs !== es) begin
      errors++; $display("FAIL %s sum got=%h exp=%h", nm, rs, es);
    end
    if (rc !== ec) begin
      errors++; $display("FAIL %s cout got=%b exp=%b", nm, rc, ec);
    end
    if (ro !== eo) begin
      errors++; $display("FAIL %s ovf got=%b exp=%b", nm, ro, eo);
    end
  endtask

  task automatic test_add();
    check_beat("add", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
    check_beat("add_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0,
               EXP_MAX_ADD, 1'b0, 1'b1);
  endtask

  task automatic test_sub();
    check_beat("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check_beat("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1,
               EXP_MIN_SUB, 1'b1, 1'b1);
  endtask

  task automatic test_ripple();
    check_beat("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_s [6];
    int idx;
    exp_s = '{16'h0101, 16'h1212, 16'h2323, 16'h3434, 16'h4545, 16'h5656};
    idx = 0;
    out_ready = 1'b1; cin = 1'b0; sub = 1'b0; b = 16'h0101;
    for (int c = 1; c <= 20; c++) begin
      in_valid = (c <= 6);
      a = 16'((c - 1) * 16'h1111);
      @(posedge clk); #1;
      if (out_valid && idx < 6) begin
        checks += 2;
        if (sum !== exp_s[idx]) begin
          errors++;
          $display("FAIL b2b_sum[%0d] got=%h exp=%h", idx, sum, exp_s[idx]);
        end
        if (c != idx + 4) begin
          errors++;
          $display("FAIL b2b_cycle[%0d] got=%0d exp=%0d", idx, c, idx + 4);
        end
        idx++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++; $display("FAIL b2b_count got=%0d exp=6", idx);
    end
  endtask

  task automatic test_backpressure();
    res_t q[$];
    res_t got;
    int tx, rx;
    logic held_v;
    logic [15:0] held_s;
    tx = 0; rx = 0; held_v = 1'b0; held_s = '0;
    for (int c = 1; c <= 60; c++) begin
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (tx < 8);
      a   = 16'(16'h1F00 * tx + 16'h0F0F);
      b   = 16'(16'h0333 * tx + 16'h7000);
      sub = tx[0];
      cin = tx[1];
      #1;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready);
        end
      end
      if (held_v) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== held_s) begin
          errors++;
          $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h",
                   c, out_valid, sum, held_s);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        got = {sum, cout, ovf};
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra c=%0d got=%h exp=none", c, sum);
        end else begin
          if (got !== q[0]) begin
            errors++;
            $display("FAIL bp_data[%0d] got=%h exp=%h", rx, got, q[0]);
          end
          void'(q.pop_front());
        end
        rx++;
      end
      held_v = out_valid && !out_ready;
      held_s = sum;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        tx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks += 2;
    if (tx != 8) begin
      errors++; $display("FAIL bp_sent got=%0d exp=8", tx);
    end
    if (rx != 8) begin
      errors++; $display("FAIL bp_recv got=%0d exp=8", rx);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b1; sub = 1'b0; cin = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      a = 16'(16'h2345 + c);
      b = 16'h4321;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    checks += 4;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid);
    end
    if (sum !== 16'h0) begin
      errors++; $display("FAIL mid_rst_sum got=%h exp=0000", sum);
    end
    if (cout !== 1'b0) begin
      errors++; $display("FAIL mid_rst_cout got=%b exp=0", cout);
    end
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf);
    end
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL mid_rst_stale got=%0d exp=0", stale);
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [15:0] corner [6];
    res_t q[$];
    res_t got;
    int tx, rx;
    corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h8001};
    tx = 0; rx = 0;
    for (int c = 0; c < 5000 && rx < N; c++) begin
      in_valid  = (tx < N) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                        : 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)]
                                        : 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        got = {sum, cout, ovf};
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_extra got=%h exp=none", got);
        end else begin
          if (got !== q[0]) begin
            errors++;
            $display("FAIL rnd_data[%0d] got=%h exp=%h", rx, got, q[0]);
          end
          void'(q.pop_front());
        end
        rx++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        tx++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (rx != N) begin
      errors++; $display("FAIL rnd_count got=%0d exp=%0d", rx, N);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
